// File: rtl/aes_inv_rounds.sv
// aes_inv_rounds: AES-128 inverse-cipher sequencing controller.
//   Holds the 128-bit working state, caches the NR+1 round keys streamed in
//   forward order by the key expander, and replays them from NR down to 0.
//   AddRoundKey is done here. InvShiftRows, InvSubBytes and InvMixColumns are
//   external combinational blocks that read sreg and return their results.
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   start, key_reload request (taken only in IDLE); reload forces a key load
//   ciphertext        block to decrypt, captured on an accepted start
//   key_in/key_valid  round-key stream (round 0 first), key_ready handshake
//   inv_shifted/inv_subbytes/inv_mixed  results of the external inverse blocks
//   sreg, round       working state and current round index
//   busy, done        activity flag, one-cycle completion pulse
//   plaintext         result, held until the next accepted start completes
module aes_inv_rounds #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         key_reload,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] inv_shifted,
  input  logic [127:0] inv_subbytes,
  input  logic [127:0] inv_mixed,
  output logic [127:0] sreg,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done,
  output logic [127:0] plaintext
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOADKEY = 3'd1;
  localparam logic [2:0] S_INIT    = 3'd2;
  localparam logic [2:0] S_ROWS    = 3'd3;
  localparam logic [2:0] S_BYTES   = 3'd4;
  localparam logic [2:0] S_ADDKEY  = 3'd5;
  localparam logic [2:0] S_COLS    = 3'd6;
  localparam logic [2:0] S_FINISH  = 3'd7;

  localparam logic [3:0] LAST = 4'(NR);
  localparam logic [3:0] FIRST_RND = 4'(NR - 1);

  logic [2:0]   state_q, state_d;
  logic [127:0] sreg_q, sreg_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   ptr_q, ptr_d;
  logic         keys_loaded_q, keys_loaded_d;
  logic         done_q, done_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] ct_hold_q, ct_hold_d;
  logic         cache_we;
  logic [127:0] rkey;

  // Key cache is not reset; keys_loaded_q guards against using stale contents.
  logic [127:0] cache_q [0:NR];

  // Round key for the current round; out-of-range indices read as zero.
  assign rkey = (round_q <= LAST) ? cache_q[round_q] : '0;

  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    round_d       = round_q;
    ptr_d         = ptr_q;
    keys_loaded_d = keys_loaded_q;
    done_d        = 1'b0;
    pt_d          = pt_q;
    ct_hold_d     = ct_hold_q;
    cache_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ct_hold_d = ciphertext;
          if (key_reload || !keys_loaded_q) begin
            state_d = S_LOADKEY;
            ptr_d   = '0;
          end else begin
            state_d = S_INIT;
          end
        end
      end
      S_LOADKEY: begin
        if (key_valid) begin
          cache_we = 1'b1;
          ptr_d    = ptr_q + 4'd1;
          if (ptr_q == LAST) begin
            keys_loaded_d = 1'b1;
            state_d       = S_INIT;
          end
        end
      end
      S_INIT: begin
        sreg_d  = ct_hold_q ^ cache_q[NR];
        round_d = FIRST_RND;
        state_d = S_ROWS;
      end
      S_ROWS: begin
        sreg_d  = inv_shifted;
        state_d = S_BYTES;
      end
      S_BYTES: begin
        sreg_d  = inv_subbytes;
        state_d = S_ADDKEY;
      end
      S_ADDKEY: begin
        sreg_d = sreg_q ^ rkey;
        if (round_q == 4'd0) begin
          pt_d    = sreg_q ^ rkey;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          state_d = S_COLS;
        end
      end
      S_COLS: begin
        // Only entered with round_q >= 1, so this never wraps.
        sreg_d  = inv_mixed;
        round_d = round_q - 4'd1;
        state_d = S_ROWS;
      end
      S_FINISH: begin
        sreg_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        sreg_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      sreg_q        <= '0;
      round_q       <= '0;
      ptr_q         <= '0;
      keys_loaded_q <= 1'b0;
      done_q        <= 1'b0;
      pt_q          <= '0;
      ct_hold_q     <= '0;
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      round_q       <= round_d;
      ptr_q         <= ptr_d;
      keys_loaded_q <= keys_loaded_d;
      done_q        <= done_d;
      pt_q          <= pt_d;
      ct_hold_q     <= ct_hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cache_we && (ptr_q <= LAST)) cache_q[ptr_q] <= key_in;
  end

  assign key_ready = (state_q == S_LOADKEY);
  assign busy      = (state_q != S_IDLE);
  assign sreg      = sreg_q;
  assign round     = round_q;
  assign done      = done_q;
  assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_inv_rounds.sv
// tb_aes_inv_rounds: directed bench for aes_inv_rounds. Supplies the inverse
// AES building blocks and the key expansion from a small GF(2^8) model and
// checks against the FIPS-197 known-answer vectors.
module tb_aes_inv_rounds;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] JUNK   = 128'hdeadbeef_cafef00d_0badc0de_12345678;

  logic         clk = 1'b0;
  logic         reset, start, key_reload, key_valid;
  logic [127:0] ciphertext, key_in;
  logic         key_ready, busy, done;
  logic [127:0] inv_shifted, inv_subbytes, inv_mixed, sreg, plaintext;
  logic [3:0]   round;

  logic [127:0] rk [0:10];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_inv_rounds #(.NR(10)) dut (
    .clk(clk), .reset(reset), .start(start), .key_reload(key_reload),
    .ciphertext(ciphertext), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .inv_shifted(inv_shifted),
    .inv_subbytes(inv_subbytes), .inv_mixed(inv_mixed), .sreg(sreg),
    .round(round), .busy(busy), .done(done), .plaintext(plaintext)
  );

  // ---------------- GF(2^8) / AES model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, a);
      a = gmul(a, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] y);
    return ginv(rl(y, 1) ^ rl(y, 3) ^ rl(y, 6) ^ 8'h05);
  endfunction

  // State byte i is bits [127-8i -: 8]; row = i%4, column = i/4.
  function automatic logic [127:0] f_isr(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] f_isb(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = isbox(s[127 - 8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] f_imc(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09);
      o[119 - 32*c -: 8] = gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d);
      o[111 - 32*c -: 8] = gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b);
      o[103 - 32*c -: 8] = gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e);
    end
    return o;
  endfunction

  assign inv_shifted  = f_isr(sreg);
  assign inv_subbytes = f_isb(sreg);
  assign inv_mixed    = f_imc(sreg);

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until done is seen high (bounded); n=-1 on timeout.
  task automatic wait_done(output int n, output bit saw_kr);
    n = -1;
    saw_kr = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (key_ready) saw_kr = 1'b1;
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic issue_start(input logic [127:0] ct, input logic reload);
    ciphertext = ct;
    key_reload = reload;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    key_reload = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b0; key_reload = 1'b0; key_valid = 1'b0;
    ciphertext = '0; key_in = '0;
    tick(); tick();
    n_cmp++;
    if ({busy, key_ready, done, round} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_flags: got busy=%b kr=%b done=%b round=%0d want all 0",
               busy, key_ready, done, round);
    end
    n_cmp++;
    if ({sreg, plaintext} !== 256'd0) begin
      n_bad++;
      $display("FAIL reset_data: got sreg=%h pt=%h want 0", sreg, plaintext);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fips_c1();
    int n;
    bit kr;
    expand(KEY_C1);
    issue_start(CT_C1, 1'b1);
    n_cmp++;
    if ({key_ready, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL c1_loadkey: got kr=%b busy=%b want 1 1", key_ready, busy);
    end
    for (int k = 0; k < 11; k++) begin
      key_valid = 1'b1; key_in = rk[k];
      tick();
    end
    key_valid = 1'b0; key_in = '0;
    n_cmp++;
    if ({key_ready, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL c1_init: got kr=%b busy=%b want 0 1", key_ready, busy);
    end
    tick();
    n_cmp++;
    if (sreg !== (CT_C1 ^ rk[10]) || round !== 4'd9) begin
      n_bad++;
      $display("FAIL c1_first_ark: got sreg=%h round=%0d want %h 9",
               sreg, round, CT_C1 ^ rk[10]);
    end
    wait_done(n, kr);
    n_cmp++;
    if (n + 1 !== 40) begin
      n_bad++;
      $display("FAIL c1_latency: got %0d want 40", n + 1);
    end
    n_cmp++;
    if (plaintext !== PT_C1) begin
      n_bad++;
      $display("FAIL c1_plaintext: got %h want %h", plaintext, PT_C1);
    end
    tick();
  endtask

  // Ends in the FINISH cycle so test_done_timing can probe it.
  task automatic test_key_reuse();
    int n;
    bit kr;
    issue_start(CT_C1, 1'b0);
    n_cmp++;
    if ({key_ready, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL reuse_init: got kr=%b busy=%b want 0 1", key_ready, busy);
    end
    wait_done(n, kr);
    n_cmp++;
    if (n + 1 !== 41 || kr !== 1'b0) begin
      n_bad++;
      $display("FAIL reuse_latency: got %0d kr_seen=%b want 41 0", n + 1, kr);
    end
    n_cmp++;
    if (plaintext !== PT_C1) begin
      n_bad++;
      $display("FAIL reuse_plaintext: got %h want %h", plaintext, PT_C1);
    end
  endtask

  task automatic test_done_timing();
    // Start in the FINISH cycle must be ignored.
    ciphertext = JUNK; key_reload = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; key_reload = 1'b0;
    n_cmp++;
    if ({done, busy} !== 2'b00 || sreg !== 128'd0) begin
      n_bad++;
      $display("FAIL done_one_cycle: got done=%b busy=%b sreg=%h want 0 0 0",
               done, busy, sreg);
    end
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b0 || plaintext !== PT_C1) begin
      n_bad++;
      $display("FAIL done_hold: got busy=%b pt=%h want 0 %h", busy, plaintext, PT_C1);
    end
  endtask

  task automatic test_key_stall();
    int n;
    int t;
    bit kr;
    bit kr_low = 1'b0;
    expand(KEY_B);
    issue_start(CT_B, 1'b1);
    t = 1;
    for (int k = 0; k < 11; k++) begin
      key_valid = 1'b1; key_in = rk[k];
      tick(); t++;
      if (k == 3) begin
        key_valid = 1'b0; key_in = JUNK;
        for (int s = 0; s < 5; s++) begin
          tick(); t++;
          if (key_ready !== 1'b1) kr_low = 1'b1;
        end
      end
    end
    key_valid = 1'b0; key_in = '0;
    n_cmp++;
    if (kr_low !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_key_ready: got dropped=%b want 0", kr_low);
    end
    wait_done(n, kr);
    n_cmp++;
    if (t + n !== 57) begin
      n_bad++;
      $display("FAIL stall_latency: got %0d want 57", t + n);
    end
    n_cmp++;
    if (plaintext !== PT_B) begin
      n_bad++;
      $display("FAIL stall_plaintext: got %h want %h", plaintext, PT_B);
    end
    tick();
  endtask

  task automatic test_spurious();
    int n = -1;
    bit kr;
    issue_start(CT_B, 1'b0);
    ciphertext = JUNK;
    for (int i = 2; i <= 200; i++) begin
      tick();
      if (done === 1'b1) begin
        n = i;
        break;
      end
      if (round == 4'd5) begin
        start = 1'b1; key_reload = 1'b1; key_valid = 1'b1; key_in = JUNK;
      end else begin
        start = 1'b0; key_reload = 1'b0; key_valid = 1'b0; key_in = '0;
      end
    end
    start = 1'b0; key_reload = 1'b0; key_valid = 1'b0;
    n_cmp++;
    if (n !== 41) begin
      n_bad++;
      $display("FAIL spurious_latency: got %0d want 41", n);
    end
    n_cmp++;
    if (plaintext !== PT_B) begin
      n_bad++;
      $display("FAIL spurious_plaintext: got %h want %h", plaintext, PT_B);
    end
    tick();
    // Cache must be intact: rerun on the stored keys.
    issue_start(CT_B, 1'b0);
    wait_done(n, kr);
    n_cmp++;
    if (plaintext !== PT_B || kr !== 1'b0) begin
      n_bad++;
      $display("FAIL spurious_cache: got %h kr_seen=%b want %h 0", plaintext, kr, PT_B);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int n;
    bit kr;
    issue_start(CT_B, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (round == 4'd4) break;
      tick();
    end
    n_cmp++;
    if (round !== 4'd4) begin
      n_bad++;
      $display("FAIL midrun_reach_round4: got %0d want 4", round);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, key_ready, done, round} !== 7'd0 || {sreg, plaintext} !== 256'd0) begin
      n_bad++;
      $display("FAIL midrun_reset: got busy=%b kr=%b done=%b round=%0d sreg=%h pt=%h want 0",
               busy, key_ready, done, round, sreg, plaintext);
    end
    tick();
    reset = 1'b1;
    tick();
    expand(KEY_C1);
    issue_start(CT_C1, 1'b0);
    n_cmp++;
    if (key_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midrun_forced_load: got kr=%b want 1", key_ready);
    end
    for (int k = 0; k < 11; k++) begin
      key_valid = 1'b1; key_in = rk[k];
      tick();
    end
    key_valid = 1'b0;
    wait_done(n, kr);
    n_cmp++;
    if (n !== 40 || plaintext !== PT_C1) begin
      n_bad++;
      $display("FAIL midrun_reload_result: got n=%0d pt=%h want 40 %h", n, plaintext, PT_C1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fips_c1();
    test_key_reuse();
    test_done_timing();
    test_key_stall();
    test_spurious();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
